// File: rtl/adder_pipe.sv
// adder_pipe: segmented ripple-carry adder/subtractor with a valid/ready
// handshake. Each pipeline stage adds SEG bits and passes its carry to the
// next stage, so a WIDTH-bit result emerges WIDTH/SEG cycles after the
// operands are accepted. A stalled output freezes the entire pipeline.
module adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int L = WIDTH / SEG;

    logic             stall;
    logic             accept;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Per-stage pipeline registers; stage L-1 drives the outputs.
    logic             valid_reg [L];
    logic             carry_reg [L];
    logic [WIDTH-1:0] opa_reg   [L];
    logic [WIDTH-1:0] opb_reg   [L];
    logic [WIDTH-1:0] sum_reg   [L];

    // What each stage sees on its input side (operands or previous stage).
    logic             src_valid [L];
    logic             src_carry [L];
    logic [WIDTH-1:0] src_opa   [L];
    logic [WIDTH-1:0] src_opb   [L];
    logic [WIDTH-1:0] src_sum   [L];

    // Values each stage will capture on the next un-stalled edge.
    logic             carry_next [L];
    logic [WIDTH-1:0] sum_next   [L];

    // A held result at the output blocks every stage, including the input.
    assign stall    = valid_reg[L-1] && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    // Subtraction is a + ~b + ~borrow_in, so the adder core only ever adds.
    assign b_eff   = mode ? ~b : b;
    assign cin_eff = mode ? ~carry_in : carry_in;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_stage
            logic [SEG-1:0]   seg_sum;
            logic [WIDTH-1:0] sum_merged;

            if (gi == 0) begin : g_first
                assign src_valid[gi] = accept;
                assign src_carry[gi] = cin_eff;
                assign src_opa[gi]   = a;
                assign src_opb[gi]   = b_eff;
                assign src_sum[gi]   = '0;
            end else begin : g_rest
                assign src_valid[gi] = valid_reg[gi-1];
                assign src_carry[gi] = carry_reg[gi-1];
                assign src_opa[gi]   = opa_reg[gi-1];
                assign src_opb[gi]   = opb_reg[gi-1];
                assign src_sum[gi]   = sum_reg[gi-1];
            end

            // This stage's slice of the addition, chained on the incoming carry.
            assign {carry_next[gi], seg_sum} =
                  {1'b0, src_opa[gi][gi*SEG +: SEG]}
                + {1'b0, src_opb[gi][gi*SEG +: SEG]}
                + {{SEG{1'b0}}, src_carry[gi]};

            // Insert the freshly computed segment into the partial sum word.
            always_comb begin
                sum_merged                 = src_sum[gi];
                sum_merged[gi*SEG +: SEG]  = seg_sum;
            end

            assign sum_next[gi] = sum_merged;
        end
    endgenerate

    // Advance every stage together unless the output is stalled; reset flushes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                valid_reg[k] <= 1'b0;
                carry_reg[k] <= 1'b0;
                opa_reg[k]   <= '0;
                opb_reg[k]   <= '0;
                sum_reg[k]   <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < L; k++) begin
                valid_reg[k] <= src_valid[k];
                carry_reg[k] <= carry_next[k];
                opa_reg[k]   <= src_opa[k];
                opb_reg[k]   <= src_opb[k];
                sum_reg[k]   <= sum_next[k];
            end
        end
    end

    assign out_valid = valid_reg[L-1];
    assign sum       = sum_reg[L-1];
    assign carry_out = carry_reg[L-1];

    // Signed overflow: effective operands share a sign that the result lacks.
    // The final stage still carries both operand MSBs, so it is derived here.
    assign overflow = (opa_reg[L-1][WIDTH-1] == opb_reg[L-1][WIDTH-1])
                   && (sum_reg[L-1][WIDTH-1] != opa_reg[L-1][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed vectors with hand-computed results. The driver
// pushes the expected response when an input is accepted; an independent
// monitor pops and compares whenever the DUT hands over a result.
module tb_adder_pipe;

    localparam int WIDTH = 16;
    localparam int SEG   = 4;
    localparam int L     = WIDTH / SEG;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
        int               cyc;
        bit               lat;
    } exp_t;

    exp_t sb_q[$];

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int results   = 0;
    int stall_cnt = 0;
    int t0        = 1000000000;
    bit stall_win = 1'b0;

    logic [WIDTH-1:0] stream_exp [8] = '{16'h0001, 16'h0004, 16'h0007, 16'h000A,
                                         16'h000D, 16'h0010, 16'h0013, 16'h0016};

    adder_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Cycle number; observed at the falling edge it names the current cycle.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Consumer: drops out_ready during cycles t0+5..t0+7 of the streaming test.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = !(stall_win && (cyc >= t0 + 5) && (cyc <= t0 + 7));
        end
    end

    // Monitor: checks handovers against the scoreboard and stall behaviour.
    initial begin : monitor
        exp_t             e;
        bit               prev_stall;
        logic [WIDTH-1:0] held_s;
        logic             held_c;
        logic             held_o;
        prev_stall = 1'b0;
        held_s     = '0;
        held_c     = 1'b0;
        held_o     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_stall = 1'b0;
            end else if (out_valid === 1'b1 && out_ready === 1'b0) begin
                stall_cnt++;
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready);
                end
                if (prev_stall) begin
                    checks++;
                    if (sum !== held_s || carry_out !== held_c || overflow !== held_o) begin
                        errors++;
                        $display("FAIL stall_hold cyc=%0d got=%h/%b/%b want=%h/%b/%b",
                                 cyc, sum, carry_out, overflow, held_s, held_c, held_o);
                    end
                end else begin
                    held_s = sum;
                    held_c = carry_out;
                    held_o = overflow;
                end
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
                if (out_valid === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_result cyc=%0d got=%h/%b/%b want=none",
                                 cyc, sum, carry_out, overflow);
                    end else begin
                        e = sb_q.pop_front();
                        results++;
                        if (sum !== e.s || carry_out !== e.c || overflow !== e.o) begin
                            errors++;
                            $display("FAIL result cyc=%0d got=%h/%b/%b want=%h/%b/%b",
                                     cyc, sum, carry_out, overflow, e.s, e.c, e.o);
                        end else begin
                            $display("result cyc=%0d sum=%h cout=%b ovf=%b ok",
                                     cyc, sum, carry_out, overflow);
                        end
                        if (e.lat) begin
                            checks++;
                            if (cyc - e.cyc != L) begin
                                errors++;
                                $display("FAIL latency got=%0d want=%0d", cyc - e.cyc, L);
                            end
                        end
                    end
                end
            end
        end
    end

    // Present one operand set, hold it until accepted, record the expectation.
    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic ci, input logic md,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                        input bit lat, output int acc_cyc);
        exp_t e;
        bit   done;
        done     = 1'b0;
        acc_cyc  = -1;
        a        = av;
        b        = bv;
        carry_in = ci;
        mode     = md;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1 && rst === 1'b0) begin
                e.s = es;
                e.c = ec;
                e.o = eo;
                e.cyc = cyc;
                e.lat = lat;
                sb_q.push_back(e);
                acc_cyc = cyc;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout a=%h b=%h got=not_accepted want=accepted", av, bv);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait, bounded, until every expected result has been handed over.
    task automatic drain();
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d pending want=0", sb_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    initial begin : main
        int acc;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        mode     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_carry_out", {15'd0, carry_out}, 16'h0000);
        chk("rst_overflow", {15'd0, overflow}, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'h0001);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Isolated vectors: result, flags and latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, acc); drain();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1, acc); drain();
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1, acc); drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1, acc); drain();
        send(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0, 1'b1, acc); drain();
        send(16'h1234, 16'h0FCB, 1'b1, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b1, acc); drain();
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, acc); drain();

        // Back-to-back stream with a three-cycle output stall.
        stall_win = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(16'(i), 16'(2 * i + 1), 1'b0, 1'b0, stream_exp[i], 1'b0, 1'b0, (i == 0), acc);
            if (i == 0) t0 = acc;
        end
        drain();
        stall_win = 1'b0;
        chk("stall_cycles", 16'(stall_cnt), 16'd3);

        // Reset with three results in flight; operands offered during reset.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, acc);
        send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, acc);
        send(16'h4000, 16'h0001, 1'b0, 1'b0, 16'h4001, 1'b0, 1'b0, 1'b0, acc);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'h00AA;
        b        = 16'h0055;
        mode     = 1'b0;
        carry_in = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", {15'd0, in_ready}, 16'h0001);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("post_rst_in_ready", {15'd0, in_ready}, 16'h0001);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b1, acc);
        drain();

        chk("result_count", 16'(results), 16'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation timeout");
    end

endmodule
